// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions.
// The register-file write request type is used by the writeback arbiter
// and by its aux FIFO.
//   REG_ADDR_W : architectural register address width
//   XLEN       : data path width
//   wb_req_t   : one register-file write request {waddr, wdata}
package riscv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [XLEN-1:0]       wdata;
    } wb_req_t;

endpackage

// File: rtl/wb_aux_fifo.sv
// Small FIFO that holds aux-unit results until they win the write port.
// It exposes the head entry and a per-slot valid/address view, so the
// parent can compare every queued destination against decode's sources.
// Ports:
//   clk_i, rst_i     : clock and asynchronous active-low reset
//   push_i           : enqueue push_req_i (ignored when full)
//   push_req_i       : entry to enqueue
//   pop_i            : dequeue the head (ignored when empty)
//   full_o, empty_o  : occupancy flags
//   head_o           : oldest entry
//   entry_valid_o    : per-slot occupied flag
//   entry_waddr_o    : per-slot destination register
module wb_aux_fifo
    import riscv_pkg::*;
#(
    parameter int AUX_DEPTH = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  push_i,
    input  wb_req_t                               push_req_i,
    input  logic                                  pop_i,
    output logic                                  full_o,
    output logic                                  empty_o,
    output wb_req_t                               head_o,
    output logic [AUX_DEPTH-1:0]                  entry_valid_o,
    output logic [AUX_DEPTH-1:0][REG_ADDR_W-1:0]  entry_waddr_o
);

    localparam int PTR_W = $clog2(AUX_DEPTH);

    // The extra MSB on each pointer tells full from empty when the
    // index bits match.
    logic [PTR_W:0] wr_ptr_reg;
    logic [PTR_W:0] rd_ptr_reg;
    logic [PTR_W:0] count;
    logic           push_ok;
    logic           pop_ok;

    wb_req_t mem_reg [AUX_DEPTH];

    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign empty_o = (wr_ptr_reg == rd_ptr_reg);
    assign full_o  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_reg[rd_ptr_reg[PTR_W-1:0]];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem_reg[wr_ptr_reg[PTR_W-1:0]] <= push_req_i;
    end

    // A slot is occupied when its distance from the read pointer
    // (modulo depth) is smaller than the current occupancy.
    generate
        for (genvar gi = 0; gi < AUX_DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] offset;
            assign offset            = PTR_W'(gi) - rd_ptr_reg[PTR_W-1:0];
            assign entry_valid_o[gi] = ({1'b0, offset} < count);
            assign entry_waddr_o[gi] = mem_reg[gi].waddr;
        end
    endgenerate

endmodule

// File: rtl/wb_arbiter.sv
// Owns the single register-file write port and shares it between the
// in-order pipe writeback and an out-of-band aux unit. Aux results wait
// in a FIFO; a starvation counter bounds how long the aux head can be
// passed over by back-to-back pipe writes. Queued aux destinations are
// reported to decode as a hazard.
// Ports:
//   clk_i, rst_i                    : clock, asynchronous active-low reset
//   pipe_write_i/waddr_i/wdata_i    : pipe write request
//   pipe_ready_o                    : pipe write accepted (0 = hold)
//   aux_valid_i/waddr_i/wdata_i     : aux result
//   aux_ready_o                     : aux FIFO can accept
//   rs1_i, rs2_i                    : decode source registers
//   hazard_o                        : a source matches a queued aux dest
//   aux_pending_o                   : aux FIFO non-empty
//   reg_write_o/waddr_o/wdata_o     : registered regfile write port
module wb_arbiter
    import riscv_pkg::*;
#(
    parameter int AUX_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pipe_write_i,
    input  logic [REG_ADDR_W-1:0] pipe_waddr_i,
    input  logic [XLEN-1:0]       pipe_wdata_i,
    output logic                  pipe_ready_o,
    input  logic                  aux_valid_i,
    input  logic [REG_ADDR_W-1:0] aux_waddr_i,
    input  logic [XLEN-1:0]       aux_wdata_i,
    output logic                  aux_ready_o,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    output logic                  hazard_o,
    output logic                  aux_pending_o,
    output logic                  reg_write_o,
    output logic [REG_ADDR_W-1:0] reg_waddr_o,
    output logic [XLEN-1:0]       reg_wdata_o
);

    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic                                 fifo_full;
    logic                                 fifo_empty;
    wb_req_t                              fifo_head;
    logic [AUX_DEPTH-1:0]                 entry_valid;
    logic [AUX_DEPTH-1:0][REG_ADDR_W-1:0] entry_waddr;
    logic [AUX_DEPTH-1:0]                 entry_hit;

    logic             pipe_req;
    logic             aux_req;
    logic             aux_push;
    logic             starve_hit;
    logic             grant_aux;
    logic             grant_pipe;
    wb_req_t          winner;

    logic [CNT_W-1:0]      starve_cnt_reg;
    logic [CNT_W-1:0]      starve_cnt_next;
    logic                  reg_write_reg;
    logic [REG_ADDR_W-1:0] reg_waddr_reg;
    logic [XLEN-1:0]       reg_wdata_reg;

    // Writes to x0 are architectural no-ops: the pipe sees them accepted
    // and the aux unit sees them handshaken, but nothing is stored.
    assign pipe_req    = pipe_write_i && (pipe_waddr_i != '0);
    assign aux_ready_o = !fifo_full;
    assign aux_push    = aux_valid_i && !fifo_full && (aux_waddr_i != '0);

    // Eligibility uses the head as of cycle start, so an entry pushed
    // this cycle only competes from the next one.
    assign aux_req    = !fifo_empty;
    assign starve_hit = (starve_cnt_reg >= CNT_W'(STARVE_MAX));
    assign grant_aux  = aux_req && (!pipe_req || starve_hit);
    assign grant_pipe = pipe_req && !grant_aux;

    assign pipe_ready_o  = !(grant_aux && pipe_req);
    assign aux_pending_o = !fifo_empty;

    assign winner = grant_aux ? fifo_head : wb_req_t'({pipe_waddr_i, pipe_wdata_i});

    wb_aux_fifo #(
        .AUX_DEPTH (AUX_DEPTH)
    ) u_aux_fifo (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .push_i        (aux_push),
        .push_req_i    (wb_req_t'({aux_waddr_i, aux_wdata_i})),
        .pop_i         (grant_aux),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty),
        .head_o        (fifo_head),
        .entry_valid_o (entry_valid),
        .entry_waddr_o (entry_waddr)
    );

    // The head being popped this cycle still counts: its value is not in
    // the regfile until after the output register, which decode forwards
    // from separately.
    generate
        for (genvar gi = 0; gi < AUX_DEPTH; gi++) begin : g_hazard
            assign entry_hit[gi] = entry_valid[gi] &&
                ((rs1_i != '0 && entry_waddr[gi] == rs1_i) ||
                 (rs2_i != '0 && entry_waddr[gi] == rs2_i));
        end
    endgenerate

    assign hazard_o = |entry_hit;

    // Counts pipe wins over a waiting aux head; any aux win, or an empty
    // FIFO, restarts the window.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (grant_aux || !aux_req)
            starve_cnt_next = '0;
        else if (grant_pipe && !starve_hit)
            starve_cnt_next = starve_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            starve_cnt_reg <= '0;
            reg_write_reg  <= 1'b0;
            reg_waddr_reg  <= '0;
            reg_wdata_reg  <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            reg_write_reg  <= grant_aux || grant_pipe;
            if (grant_aux || grant_pipe) begin
                reg_waddr_reg <= winner.waddr;
                reg_wdata_reg <= winner.wdata;
            end
        end
    end

    assign reg_write_o = reg_write_reg;
    assign reg_waddr_o = reg_waddr_reg;
    assign reg_wdata_o = reg_wdata_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
    import riscv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        pipe_write_i = 1'b0;
    logic [4:0]  pipe_waddr_i = '0;
    logic [31:0] pipe_wdata_i = '0;
    logic        pipe_ready_o;
    logic        aux_valid_i = 1'b0;
    logic [4:0]  aux_waddr_i = '0;
    logic [31:0] aux_wdata_i = '0;
    logic        aux_ready_o;
    logic [4:0]  rs1_i = '0;
    logic [4:0]  rs2_i = '0;
    logic        hazard_o;
    logic        aux_pending_o;
    logic        reg_write_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;

    int checks = 0;
    int errors = 0;
    wb_req_t exp_q[$];
    wb_req_t mon_e;

    wb_arbiter #(.AUX_DEPTH(2), .STARVE_MAX(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pipe_write_i  (pipe_write_i),
        .pipe_waddr_i  (pipe_waddr_i),
        .pipe_wdata_i  (pipe_wdata_i),
        .pipe_ready_o  (pipe_ready_o),
        .aux_valid_i   (aux_valid_i),
        .aux_waddr_i   (aux_waddr_i),
        .aux_wdata_i   (aux_wdata_i),
        .aux_ready_o   (aux_ready_o),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .hazard_o      (hazard_o),
        .aux_pending_o (aux_pending_o),
        .reg_write_o   (reg_write_o),
        .reg_waddr_o   (reg_waddr_o),
        .reg_wdata_o   (reg_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic set_pipe(input logic w, input logic [4:0] a, input logic [31:0] d);
        pipe_write_i = w;
        pipe_waddr_i = a;
        pipe_wdata_i = d;
    endtask

    task automatic set_aux(input logic v, input logic [4:0] a, input logic [31:0] d);
        aux_valid_i = v;
        aux_waddr_i = a;
        aux_wdata_i = d;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wb_req_t e;
        e.waddr = a;
        e.wdata = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every regfile write is popped against the scoreboard.
    always @(negedge clk_i) begin
        if (rst_i && reg_write_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=x%0d/0x%08h required=none",
                         reg_waddr_o, reg_wdata_o);
            end else begin
                mon_e = exp_q.pop_front();
                $display("write x%0d = 0x%08h (expected x%0d = 0x%08h)",
                         reg_waddr_o, reg_wdata_o, mon_e.waddr, mon_e.wdata);
                check("wb_addr", 32'(reg_waddr_o), 32'(mon_e.waddr));
                check("wb_data", reg_wdata_o, mon_e.wdata);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;

        // Reset with two queued aux entries.
        step(); set_pipe(1, 5'd1, 32'h11); set_aux(1, 5'd3, 32'h33); expect_wr(5'd1, 32'h11);
        step(); set_pipe(1, 5'd2, 32'h22); set_aux(1, 5'd4, 32'h44); expect_wr(5'd2, 32'h22);
        step(); set_pipe(0, 5'd0, 32'h0); set_aux(0, 5'd0, 32'h0);
        #1 rst_i = 1'b0;
        #1;
        check("rst_reg_write", 32'(reg_write_o), 32'd0);
        check("rst_aux_pending", 32'(aux_pending_o), 32'd0);
        check("rst_aux_ready", 32'(aux_ready_o), 32'd1);
        @(negedge clk_i); #1 rst_i = 1'b1;
        repeat (3) step();

        // Pipe only.
        step(); set_pipe(1, 5'd5, 32'hDEADBEEF); #1;
        check("pipe_only_ready", 32'(pipe_ready_o), 32'd1);
        expect_wr(5'd5, 32'hDEADBEEF);
        step(); set_pipe(0, 5'd0, 32'h0); #1;
        check("pipe_idle_ready", 32'(pipe_ready_o), 32'd1);

        // Idle pipe, aux x7 with hazard queries.
        step(); set_aux(1, 5'd7, 32'h1234); #1;
        check("aux_ready_idle", 32'(aux_ready_o), 32'd1);
        expect_wr(5'd7, 32'h1234);
        step(); set_aux(0, 5'd0, 32'h0); rs1_i = 5'd7; #1;
        check("hazard_rs1", 32'(hazard_o), 32'd1);
        check("aux_pending_q", 32'(aux_pending_o), 32'd1);
        rs1_i = 5'd0; rs2_i = 5'd7; #1;
        check("hazard_rs2", 32'(hazard_o), 32'd1);
        step(); #1;
        check("hazard_after_deq", 32'(hazard_o), 32'd0);
        check("aux_write_now", 32'(reg_write_o), 32'd1);
        check("aux_write_addr", 32'(reg_waddr_o), 32'd7);
        rs2_i = 5'd0;
        step();

        // Starvation: five pipe wins, then aux x9, then the held pipe write.
        for (int i = 0; i < 5; i++) expect_wr(5'(10 + i), 32'h100 + 32'(i));
        expect_wr(5'd9, 32'h9999);
        expect_wr(5'd15, 32'h105);
        for (int c = 0; c < 7; c++) begin
            int idx;
            idx = (c < 5) ? c : 5;
            step();
            set_pipe(1, 5'(10 + idx), 32'h100 + 32'(idx));
            set_aux(c == 0, 5'd9, 32'h9999);
            #1;
            check($sformatf("starve_ready_c%0d", c), 32'(pipe_ready_o), (c != 5) ? 32'd1 : 32'd0);
        end
        step(); set_pipe(0, 5'd0, 32'h0); set_aux(0, 5'd0, 32'h0);
        repeat (2) step();

        // FIFO full with pipe saturating.
        for (int i = 0; i < 5; i++) expect_wr(5'(20 + i), 32'h200 + 32'(i));
        expect_wr(5'd17, 32'hA000_0001);
        expect_wr(5'd25, 32'h205);
        expect_wr(5'd18, 32'hA000_0002);
        expect_wr(5'd19, 32'hA000_0003);
        for (int c = 0; c < 7; c++) begin
            int idx;
            idx = (c < 5) ? c : 5;
            step();
            set_pipe(1, 5'(20 + idx), 32'h200 + 32'(idx));
            if (c == 0)      set_aux(1, 5'd17, 32'hA000_0001);
            else if (c == 1) set_aux(1, 5'd18, 32'hA000_0002);
            else             set_aux(1, 5'd19, 32'hA000_0003);
            #1;
            check($sformatf("full_aux_ready_c%0d", c), 32'(aux_ready_o),
                  (c < 2 || c == 6) ? 32'd1 : 32'd0);
            check($sformatf("full_pipe_ready_c%0d", c), 32'(pipe_ready_o),
                  (c != 5) ? 32'd1 : 32'd0);
        end
        step(); set_pipe(0, 5'd0, 32'h0); set_aux(0, 5'd0, 32'h0);
        repeat (4) step();

        // x0 filtering.
        step(); set_pipe(1, 5'd0, 32'hFFFF); set_aux(1, 5'd0, 32'hEEEE); #1;
        check("x0_pipe_ready", 32'(pipe_ready_o), 32'd1);
        check("x0_aux_ready", 32'(aux_ready_o), 32'd1);
        step(); set_pipe(0, 5'd0, 32'h0); set_aux(0, 5'd0, 32'h0); rs1_i = 5'd0; #1;
        check("x0_pending", 32'(aux_pending_o), 32'd0);
        check("x0_hazard", 32'(hazard_o), 32'd0);
        repeat (4) step();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Owns the single register-file write port and shares it between two requesters.
- Pipe: the in-order writeback from wbstage.
- Aux: a multi-cycle unit such as load-return or mul/div, which completes out of band.
Aux results are queued in a small FIFO and merged onto the port without starving either side. The block also reports a hazard for queued aux destinations so decode can stall. It sits between wbstage/aux unit and the regfile write port.

Parameters:
AUX_DEPTH, 2, aux FIFO entries (power of 2, >=2)
STARVE_MAX, 4, consecutive pipe grants allowed while aux head waits; 0 = aux always wins

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
pipe_write_i  in  1  pipe requests a write this cycle
pipe_waddr_i  in  5  pipe destination register
pipe_wdata_i  in  32  pipe write data
pipe_ready_o  out  1  pipe write accepted this cycle; 0 = pipe must hold/stall
aux_valid_i  in  1  aux result valid
aux_waddr_i  in  5  aux destination register
aux_wdata_i  in  32  aux result data
aux_ready_o  out  1  aux FIFO can accept
rs1_i  in  5  decode source 1 query
rs2_i  in  5  decode source 2 query
hazard_o  out  1  rs1/rs2 matches a queued aux destination
aux_pending_o  out  1  aux FIFO non-empty
reg_write_o  out  1  regfile write enable
reg_waddr_o  out  5  regfile write address
reg_wdata_o  out  32  regfile write data

Behaviour:
- Reset (rst_i=0, async):
  - FIFO emptied; starve_cnt=0.
  - reg_write_o=0, reg_waddr_o=0, reg_wdata_o=0.
  - Queued aux results are discarded; the aux unit must reissue.
  - Combinational outputs follow the emptied state: aux_ready_o=1, aux_pending_o=0, hazard_o=0.
- Aux enqueue:
  - Occurs when aux_valid_i && aux_ready_o; aux_ready_o = !full (combinational).
  - No enqueue when full, even if a dequeue happens in the same cycle.
  - aux_waddr_i==0 is handshaken (accepted) but not stored.
- Eligibility:
  - pipe_req = pipe_write_i && pipe_waddr_i!=0.
  - aux_req = FIFO non-empty (head as of cycle start). An entry enqueued this cycle is not eligible until next cycle.
- Grant, combinational per cycle:
  - aux if aux_req && (!pipe_req || starve_cnt>=STARVE_MAX).
  - Otherwise pipe if pipe_req.
  - Otherwise none.
- pipe_ready_o = !(aux granted && pipe_req).
  - Pipe writes to x0, and cycles with pipe_write_i=0, always see ready=1 and produce no write.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when pipe is granted while aux_req=1.
  - Clears on aux grant or when the FIFO is empty.
- Output register, 1-cycle latency:
  - On grant: reg_write_o<=1 and addr/data taken from the winner.
  - With no grant: reg_write_o<=0, and addr/data hold their previous values.
- Aux grant dequeues the FIFO head in the same cycle.
- Pointers wrap modulo AUX_DEPTH; full/empty are tracked with an extra pointer bit.
- hazard_o (combinational) = any valid FIFO entry with waddr == rs1_i (rs1_i!=0) or == rs2_i (rs2_i!=0).
  - Entries dequeued this cycle still count.
  - The in-flight output register is excluded; forwarding for it is handled elsewhere.
- aux_pending_o = !empty.
- Same-address ordering: if pipe and aux head both target rd, the grant order decides which value lands last. Avoiding that conflict is decode's job, using hazard_o.

Decomposition:
- riscv_pkg gains:
  - REG_ADDR_W=5 and XLEN=32.
  - wb_req_t, a packed struct {waddr[4:0], wdata[31:0]}, used for FIFO entries and the arbiter winner mux.
- One sub-module, wb_aux_fifo:
  - Parameterised by AUX_DEPTH; same clk_i/rst_i.
  - Ports: push/pop/full/empty, head wb_req_t, plus an entry-valid/address vector for the hazard compare.
- Arbiter, counter and output register live in wb_arbiter.

Test Plan:
- Reset state: assert rst_i=0 mid-run with 2 queued aux entries -> immediately reg_write_o=0, aux_pending_o=0, aux_ready_o=1; after release no stale write appears.
- Pipe only: pipe write x5=0xDEADBEEF -> next cycle reg_write_o=1, reg_waddr_o=5, reg_wdata_o=0xDEADBEEF; pipe_ready_o=1 throughout.
- Idle pipe:
  - Enqueue aux x7=0x1234 -> x7 written 2 cycles after the enqueue edge.
  - While queued with rs1_i=7, hazard_o=1.
  - After the dequeue, hazard_o=0.
- Starvation: STARVE_MAX=4, pipe writes every cycle, aux x9 queued -> 4 pipe writes, then the 5th cycle has pipe_ready_o=0 with x9 written; the pipe write is retried and lands next.
- FIFO full: AUX_DEPTH=2, pipe saturating with STARVE_MAX=4, 3 aux pushes -> aux_ready_o=0 after 2; the third is held until a dequeue; order is preserved.
- x0 filtering: pipe write x0 and aux write x0 -> both handshaken, no reg_write_o, FIFO stays empty, hazard_o=0 for rs1_i=0.
